regfile_nrnw: RTL and testbench



---
 rtl/regfile_nrnw.sv | 117 +++++++++++
 tb/tb_regfile_nrnw.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nrnw.sv
// Multi-ported register file with a sequenced clear sweep, sticky range error,
// and optional same-cycle write-to-read bypass.
module regfile_nrnw #(
  parameter int addr_width = 5,
  parameter int data_width = 32,
  parameter int lo         = 0,
  parameter int hi         = 31,
  parameter int n_read     = 5,
  parameter int n_write    = 2,
  parameter int bypass     = 1,
  parameter logic [data_width-1:0] init_val = '0
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [n_write-1:0]              WE,
  input  logic [n_write*addr_width-1:0]   ADDR_WR,
  input  logic [n_write*data_width-1:0]   D_IN,
  input  logic [n_read*addr_width-1:0]    ADDR_RD,
  output logic [n_read*data_width-1:0]    D_OUT,
  input  logic                            CLR,
  output logic                            BUSY,
  output logic                            ERR
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam int DEPTH = 2**addr_width;
  localparam logic [addr_width-1:0] LO_A = addr_width'(lo);
  localparam logic [addr_width-1:0] HI_A = addr_width'(hi);

  state_t                  state_q, state_d;
  logic [addr_width-1:0]   cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [data_width-1:0]   arr_q [DEPTH];
  logic                    wr_ok;
  logic [n_read*data_width-1:0] rd_data;

  function automatic logic in_rng(input logic [addr_width-1:0] a);
    int ai;
    ai = int'(a);
    return (ai >= lo) && (ai <= hi);
  endfunction

  assign wr_ok = (state_q == READY) && !CLR;
  assign BUSY  = (state_q == CLEAR);
  assign ERR   = err_q;
  assign D_OUT = rd_data;

  always_comb begin
    logic [addr_width-1:0] wa;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wa      = '0;
    if (state_q == CLEAR) begin
      // A restart request takes priority over finishing the sweep.
      if (CLR)                 cnt_d = LO_A;
      else if (cnt_q == HI_A)  state_d = READY;
      else                     cnt_d = cnt_q + 1'b1;
    end else if (CLR) begin
      state_d = CLEAR;
      cnt_d   = LO_A;
    end
    if (state_q == READY) begin
      for (int p = 0; p < n_write; p++) begin
        wa = ADDR_WR[p*addr_width +: addr_width];
        if (WE[p] && !in_rng(wa)) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= LO_A;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == CLEAR) begin
        arr_q[cnt_q] <= init_val;
      end else if (wr_ok) begin
        // Ascending port order lets the highest-index port win a collision.
        for (int p = 0; p < n_write; p++) begin
          if (WE[p] && in_rng(ADDR_WR[p*addr_width +: addr_width]))
            arr_q[ADDR_WR[p*addr_width +: addr_width]] <= D_IN[p*data_width +: data_width];
        end
      end
    end
  end

  always_comb begin
    logic [addr_width-1:0] ra;
    logic [addr_width-1:0] wa;
    logic [data_width-1:0] val;
    rd_data = '0;
    ra      = '0;
    wa      = '0;
    val     = init_val;
    for (int r = 0; r < n_read; r++) begin
      ra  = ADDR_RD[r*addr_width +: addr_width];
      val = init_val;
      if (state_q == READY && in_rng(ra)) begin
        val = arr_q[ra];
        if (bypass != 0 && wr_ok) begin
          for (int p = 0; p < n_write; p++) begin
            wa = ADDR_WR[p*addr_width +: addr_width];
            if (WE[p] && wa == ra) val = D_IN[p*data_width +: data_width];
          end
        end
      end
      rd_data[r*data_width +: data_width] = val;
    end
  end

endmodule

// File: tb/tb_regfile_nrnw.sv
// Bench for regfile_nrnw: default build, a no-bypass build on shared stimulus,
// and a hi=23 build for range-error behaviour.
module tb_regfile_nrnw;
  localparam int AW = 5, DW = 32, NR = 5, NW = 2, N = 32, N2 = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, clr;
  logic [NW-1:0]     we;
  logic [NW*AW-1:0]  awr;
  logic [NW*DW-1:0]  din;
  logic [NR*AW-1:0]  ard;
  logic [NR*DW-1:0]  dout0, dout1;
  logic              busy0, busy1, err0, err1;

  logic              rst2, clr2;
  logic [NW-1:0]     we2;
  logic [NW*AW-1:0]  awr2;
  logic [NW*DW-1:0]  din2;
  logic [NR*AW-1:0]  ard2;
  logic [NR*DW-1:0]  dout2;
  logic              busy2, err2;

  regfile_nrnw u_byp (
    .CLK(clk), .RST(rst), .WE(we), .ADDR_WR(awr), .D_IN(din), .ADDR_RD(ard),
    .D_OUT(dout0), .CLR(clr), .BUSY(busy0), .ERR(err0));

  regfile_nrnw #(.bypass(0)) u_nb (
    .CLK(clk), .RST(rst), .WE(we), .ADDR_WR(awr), .D_IN(din), .ADDR_RD(ard),
    .D_OUT(dout1), .CLR(clr), .BUSY(busy1), .ERR(err1));

  regfile_nrnw #(.hi(23)) u_rng (
    .CLK(clk), .RST(rst2), .WE(we2), .ADDR_WR(awr2), .D_IN(din2), .ADDR_RD(ard2),
    .D_OUT(dout2), .CLR(clr2), .BUSY(busy2), .ERR(err2));

  int total = 0;
  int bad   = 0;

  // Reference: sweep modelled as cycles remaining; contents reset when a sweep starts.
  int          left_m;
  bit          err_m;
  logic [31:0] mem_m [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      left_m = N; err_m = 1'b0;
      for (int i = 0; i < N; i++) mem_m[i] = '0;
    end else if (left_m > 0) begin
      if (clr) left_m = N;
      else     left_m = left_m - 1;
    end else if (clr) begin
      left_m = N;
      for (int i = 0; i < N; i++) mem_m[i] = '0;
    end else begin
      for (int p = 0; p < NW; p++)
        if (we[p]) mem_m[awr[p*AW +: AW]] = din[p*DW +: DW];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input int r, input bit byp);
    logic [AW-1:0] ra;
    logic [31:0]   v;
    ra = ard[r*AW +: AW];
    if (left_m > 0) return '0;
    v = mem_m[ra];
    if (byp && !clr)
      for (int p = 0; p < NW; p++)
        if (we[p] && awr[p*AW +: AW] == ra) v = din[p*DW +: DW];
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " busy byp"}, 32'(busy0), 32'(left_m > 0));
    chk({tag, " busy nb"},  32'(busy1), 32'(left_m > 0));
    chk({tag, " err byp"},  32'(err0),  32'(err_m));
    chk({tag, " err nb"},   32'(err1),  32'(err_m));
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("%s rd%0d byp", tag, r), dout0[r*DW +: DW], exp_rd(r, 1'b1));
      chk($sformatf("%s rd%0d nb",  tag, r), dout1[r*DW +: DW], exp_rd(r, 1'b0));
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] exp);
    for (int r = 0; r < NR; r++)
      chk($sformatf("%s rd%0d", tag, r), dout2[r*DW +: DW], exp);
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] d0, d1;
    logic [4:0]  ra;
    logic [31:0] e_byp, e_nb, e_next;
  } vec_t;

  vec_t tv [7];

  initial begin
    int n, n2;
    tv[0] = '{2'b01, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        5'd3,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
    tv[1] = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22,       5'd7,  32'h22,       32'h0,        32'h22};
    tv[2] = '{2'b10, 5'd0,  5'd3,  32'h0,        32'h12345678, 5'd3,  32'h12345678, 32'hDEADBEEF, 32'h12345678};
    tv[3] = '{2'b01, 5'd0,  5'd1,  32'hCAFEF00D, 32'h0,        5'd0,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D};
    tv[4] = '{2'b11, 5'd31, 5'd30, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd31, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5};
    tv[5] = '{2'b00, 5'd7,  5'd0,  32'hFFFFFFFF, 32'h0,        5'd7,  32'h22,       32'h22,       32'h22};
    tv[6] = '{2'b11, 5'd9,  5'd7,  32'h1,        32'h33,       5'd9,  32'h1,        32'h0,        32'h1};

    rst = 1; clr = 0; we = '0; awr = '0; din = '0; ard = '0;
    rst2 = 1; clr2 = 0; we2 = '0; awr2 = '0; din2 = '0; ard2 = '0;
    left_m = N; err_m = 0;
    for (int i = 0; i < N; i++) mem_m[i] = '0;
    settle();
    tick();
    check_all("reset");
    chk("reset busy hi23", 32'(busy2), 32'd1);
    chk("reset err hi23",  32'(err2),  32'd0);
    chk2("reset hi23", 32'h0);

    rst = 0; rst2 = 0; settle();
    n = 0; n2 = 0;
    while ((busy0 || busy2) && n < 100) begin
      if (busy0) n++;
      if (busy2) n2++;
      check_all("sweep");
      tick();
    end
    chk("reset sweep len",      32'(n),  32'(N));
    chk("reset sweep len hi23", 32'(n2), 32'(N2));
    for (int a = 0; a < N; a++) begin
      ard = {NR{5'(a)}}; settle();
      check_all("init read");
      tick();
    end

    for (int i = 0; i < 7; i++) begin
      we = tv[i].we; awr = {tv[i].wa1, tv[i].wa0}; din = {tv[i].d1, tv[i].d0};
      ard = {NR{tv[i].ra}}; settle();
      chk($sformatf("vec%0d same byp", i), dout0[2*DW +: DW], tv[i].e_byp);
      chk($sformatf("vec%0d same nb", i),  dout1[2*DW +: DW], tv[i].e_nb);
      tick();
      we = '0; settle();
      chk($sformatf("vec%0d next byp", i), dout0[2*DW +: DW], tv[i].e_next);
      chk($sformatf("vec%0d next nb", i),  dout1[2*DW +: DW], tv[i].e_next);
      tick();
    end

    for (int i = 0; i < 16; i++) begin
      we = 2'b11; awr = {5'(2*i+1), 5'(2*i)}; din = {32'(2*i+1), 32'(2*i)};
      settle(); check_all("fill"); tick();
    end
    we = '0;
    for (int a = 0; a < N; a++) begin
      ard = {NR{5'(a)}}; settle(); check_all("fill read"); tick();
    end
    clr = 1; settle(); tick(); clr = 0;
    n = 0;
    while (busy0 && n < 100) begin
      if (n == 10) begin we = 2'b01; awr = {5'd0, 5'd5}; din = {32'h0, 32'hAA}; end
      else we = '0;
      settle(); check_all("flush"); tick(); n++;
    end
    we = '0;
    chk("flush sweep len", 32'(n), 32'(N));
    for (int a = 0; a < N; a++) begin
      ard = {NR{5'(a)}}; settle(); check_all("flush read"); tick();
    end
    ard = {NR{5'd5}}; settle();
    chk("flush drop addr5", dout0[0 +: DW], 32'h0);

    clr = 1; settle(); tick(); clr = 0;
    n = 0;
    while (busy0 && n < 100) begin
      clr = (n == 20); settle(); check_all("restart"); tick(); n++;
    end
    clr = 0;
    chk("restart sweep len", 32'(n), 32'(21 + N));

    clr = 1; settle(); tick(); clr = 0;
    n = 0;
    while (busy0 && n < 15) begin tick(); n++; end
    rst = 1; settle(); tick(); rst = 0; settle();
    n = 0;
    while (busy0 && n < 100) begin check_all("abort"); tick(); n++; end
    chk("abort sweep len", 32'(n), 32'(N));

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = ($urandom_range(0, 39) == 0);
      we  = clr ? 2'b00 : 2'($urandom);
      awr = 10'($urandom);
      if ($urandom_range(0, 1) == 1) awr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      din = {$urandom, $urandom};
      ard = 25'($urandom);
      if ($urandom_range(0, 1) == 1) ard = {NR{awr[AW +: AW]}};
      settle(); check_all("rnd"); tick();
    end
    rst = 0; clr = 0; we = '0;

    we2 = 2'b11; awr2 = {5'd0, 5'd23}; din2 = {32'h99, 32'h77}; settle(); tick();
    we2 = '0; ard2 = {NR{5'd23}}; settle();
    chk2("hi23 addr23", 32'h77);
    tick();
    ard2 = {NR{5'd0}}; settle();
    chk2("hi23 addr0", 32'h99);
    chk("hi23 err in range", 32'(err2), 32'd0);
    tick();
    ard2 = {NR{5'd24}}; settle();
    chk2("hi23 oor read", 32'h0);
    tick();
    we2 = 2'b10; awr2 = {5'd24, 5'd0}; din2 = {32'h55, 32'h0}; settle();
    chk("hi23 err before edge", 32'(err2), 32'd0);
    tick();
    we2 = '0; settle();
    chk("hi23 err set", 32'(err2), 32'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin if (!err2) n++; tick(); end
    chk("hi23 err hold", 32'(n), 32'd0);
    ard2 = {NR{5'd23}}; settle();
    chk2("hi23 addr23 kept", 32'h77);
    clr2 = 1; settle(); tick(); clr2 = 0; settle();
    chk("hi23 clr busy", 32'(busy2), 32'd1);
    n = 0;
    while (busy2 && n < 100) begin tick(); n++; end
    chk("hi23 clr sweep len", 32'(n), 32'(N2));
    chk("hi23 err after clr", 32'(err2), 32'd1);
    chk2("hi23 addr23 cleared", 32'h0);
    rst2 = 1; settle(); tick(); rst2 = 0; settle();
    chk("hi23 err rst", 32'(err2), 32'd0);
    chk("hi23 busy rst", 32'(busy2), 32'd1);
    we2 = 2'b10; awr2 = {5'd30, 5'd0}; settle(); tick();
    we2 = '0; settle();
    chk("hi23 err clear-state write", 32'(err2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
